instr_mem_pipe: RTL

- Parametrised, synchronous instruction memory for the pipelined CPU fetch stage.
- Replaces the fixed 32-word combinational instruction ROM.
- Adds the following:
  - configurable depth and read latency;
  - valid/ready fetch handshake with backpressure;
  - flush on redirect;
  - a program-load write port;
  - fault flagging for misaligned or out-of-range PCs.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/instr_mem_array.sv | 28 ++
 rtl/instr_mem_pipe.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-side types and constants for the CPU front end.
// The fetch response bundle travels as one packed struct through the pipeline.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc;
        logic               fault;
    } fetch_rsp_t;

    // A PC is unusable if it is not word aligned or points past the array.
    function automatic logic pc_fault(input logic [31:0] pc, input int unsigned idx_w);
        return (pc[1:0] != 2'b00) || ((pc >> (idx_w + 2)) != 32'h0);
    endfunction

endpackage

// File: rtl/instr_mem_array.sv
// DEPTH x 32 instruction store: synchronous program-load write, read sampled by the
// caller on the acceptance edge. Contents are never reset.
module instr_mem_array
    import cpu_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               wr_en_i,
    input  logic [IDX_W-1:0]   wr_addr_i,
    input  logic [INSTR_W-1:0] wr_data_i,
    input  logic [IDX_W-1:0]   rd_addr_i,
    output logic [INSTR_W-1:0] rd_data_o
);

    logic [INSTR_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Writes and fetch acceptance never share a cycle, so this read is collision-free.
    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/instr_mem_pipe.sv
// Pipelined instruction memory with valid/ready fetch, flush, program load and PC faults.
// Latency LATENCY (1 or 2) cycles; any stalled output holds the whole pipeline.
module instr_mem_pipe
    import cpu_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int IDX_W   = $clog2(DEPTH),
    parameter int LATENCY = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [31:0]        pc_addr_i,
    output logic               resp_valid_o,
    input  logic               resp_ready_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [31:0]        pc_o,
    output logic               fault_o,
    input  logic               flush_i,
    input  logic               load_en_i,
    input  logic [IDX_W-1:0]   load_addr_i,
    input  logic [INSTR_W-1:0] load_data_i
);

    logic               stall;
    logic               accept;
    logic               req_fault;
    logic [INSTR_W-1:0] rd_data;
    fetch_rsp_t         new_rsp;

    logic       out_vld_q, out_vld_d;
    fetch_rsp_t out_rsp_q, out_rsp_d;

    instr_mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk_i     (clk_i),
        .wr_en_i   (load_en_i),
        .wr_addr_i (load_addr_i),
        .wr_data_i (load_data_i),
        .rd_addr_i (pc_addr_i[IDX_W+1:2]),
        .rd_data_o (rd_data)
    );

    assign stall       = out_vld_q && !resp_ready_i;
    assign req_ready_o = !rst_i && !flush_i && !load_en_i && !stall;
    assign accept      = req_valid_i && req_ready_o;
    assign req_fault   = pc_fault(pc_addr_i, IDX_W);

    always_comb begin
        new_rsp.instr = req_fault ? NOP_INSTR : rd_data;
        new_rsp.pc    = pc_addr_i;
        new_rsp.fault = req_fault;
    end

    if (LATENCY == 1) begin : g_lat1
        always_comb begin
            out_vld_d = out_vld_q;
            out_rsp_d = out_rsp_q;
            if (flush_i) begin
                out_vld_d = 1'b0;
            end else if (!stall) begin
                out_vld_d = accept;
                if (accept) begin
                    out_rsp_d = new_rsp;
                end
            end
        end
    end else begin : g_lat2
        logic       s1_vld_q, s1_vld_d;
        fetch_rsp_t s1_rsp_q, s1_rsp_d;

        always_comb begin
            s1_vld_d  = s1_vld_q;
            s1_rsp_d  = s1_rsp_q;
            out_vld_d = out_vld_q;
            out_rsp_d = out_rsp_q;
            if (flush_i) begin
                s1_vld_d  = 1'b0;
                out_vld_d = 1'b0;
            end else if (!stall) begin
                s1_vld_d  = accept;
                out_vld_d = s1_vld_q;
                if (accept) begin
                    s1_rsp_d = new_rsp;
                end
                if (s1_vld_q) begin
                    out_rsp_d = s1_rsp_q;
                end
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                s1_vld_q <= 1'b0;
            end else begin
                s1_vld_q <= s1_vld_d;
            end
        end

        // Stage data is only meaningful under s1_vld_q, so it carries no reset.
        always_ff @(posedge clk_i) begin
            s1_rsp_q <= s1_rsp_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_vld_q <= 1'b0;
            out_rsp_q <= '0;
        end else begin
            out_vld_q <= out_vld_d;
            out_rsp_q <= out_rsp_d;
        end
    end

    assign resp_valid_o = out_vld_q;
    assign instr_o      = out_rsp_q.instr;
    assign pc_o         = out_rsp_q.pc;
    assign fault_o      = out_rsp_q.fault;

endmodule
